// File: rtl/mcb_dat_path_pkg.sv
// Shared widths and word types for the MCB data path.
// Write FIFO words carry the byte mask alongside the data.
package mcb_dat_path_pkg;

    localparam int DQ_W     = 16;
    localparam int DM_W     = DQ_W / 8;
    localparam int WF_DEPTH = 4;
    localparam int WF_AW    = $clog2(WF_DEPTH);

    typedef logic [WF_AW:0]   wf_lvl_t;
    typedef logic [WF_AW-1:0] wf_ptr_t;

    typedef struct packed {
        logic [DM_W-1:0] dm;
        logic [DQ_W-1:0] dq;
    } wf_word_t;

endpackage

// File: rtl/mcb_dat_path_if.sv
// Controller/user-side bundle of the data path: write data,
// data-phase strobes and returned read data.
interface mcb_dat_path_if;
    import mcb_dat_path_pkg::*;

    logic            mcb_wdat_req;
    logic [DQ_W-1:0] mcb_wdat;
    logic [DM_W-1:0] mcb_wdm;
    logic            d_wr_ld;
    logic            d_dp_oe;
    logic            d_dp_ie;
    logic [DQ_W-1:0] mcb_rdat;

    modport master (
        output mcb_wdat_req,
        output mcb_wdat,
        output mcb_wdm,
        output d_wr_ld,
        output d_dp_oe,
        output d_dp_ie,
        input  mcb_rdat
    );

    modport slave (
        input  mcb_wdat_req,
        input  mcb_wdat,
        input  mcb_wdm,
        input  d_wr_ld,
        input  d_dp_oe,
        input  d_dp_ie,
        output mcb_rdat
    );

endinterface

// File: rtl/mcb_wdat_fifo.sv
// Write-data prefetch FIFO with fall-through when empty and
// sticky overflow/underflow flags.
module mcb_wdat_fifo
    import mcb_dat_path_pkg::*;
(
    input  logic     mcb_clk,
    input  logic     mcb_rst,
    input  logic     mcb_sclr_n,
    input  logic     push,
    input  wf_word_t push_word,
    input  logic     pop,
    output wf_word_t pop_word,
    output logic     pop_vld,
    output wf_lvl_t  lvl,
    output logic     ovf,
    output logic     udf
);

    localparam wf_lvl_t FULL_LVL = wf_lvl_t'(WF_DEPTH);

    wf_word_t mem [WF_DEPTH];
    wf_ptr_t  wr_ptr;
    wf_ptr_t  rd_ptr;

    logic empty;
    logic full;
    logic bypass;
    logic do_push;
    logic do_pop;

    assign empty   = (lvl == '0);
    assign full    = (lvl == FULL_LVL);
    assign bypass  = empty & push & pop;
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign do_push = push & ~bypass & (~full | pop);

    assign pop_vld  = do_pop | bypass;
    assign pop_word = bypass ? push_word : mem[rd_ptr];

    always_ff @(posedge mcb_clk) begin
        if (do_push)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (!mcb_sclr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + WF_AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + WF_AW'(1);
            if (do_push && !do_pop)
                lvl <= lvl + wf_lvl_t'(1);
            else if (do_pop && !do_push)
                lvl <= lvl - wf_lvl_t'(1);
            if (push && full && !pop)
                ovf <= 1'b1;
            if (pop && empty && !push)
                udf <= 1'b1;
        end
    end

endmodule

// File: rtl/mcb_dat_path.sv
// SDR SDRAM data path: write prefetch FIFO into pad DQ/DM regs,
// read capture of pad DQ into the user read-data register.
module mcb_dat_path
    import mcb_dat_path_pkg::*;
(
    input  logic            mcb_clk,
    input  logic            mcb_rst,
    input  logic            mcb_sclr_n,
    mcb_dat_path_if.slave   bus,
    input  logic [DQ_W-1:0] sdr_dq_i,
    output logic [DQ_W-1:0] sdr_dq_o,
    output logic            sdr_dq_oe,
    output logic [DM_W-1:0] sdr_dm_o,
    output wf_lvl_t         wf_lvl,
    output logic            wf_ovf,
    output logic            wf_udf
);

    wf_word_t push_word;
    wf_word_t pop_word;
    logic     pop_vld;

    assign push_word.dm = bus.mcb_wdm;
    assign push_word.dq = bus.mcb_wdat;

    mcb_wdat_fifo u_fifo (
        .mcb_clk    (mcb_clk),
        .mcb_rst    (mcb_rst),
        .mcb_sclr_n (mcb_sclr_n),
        .push       (bus.mcb_wdat_req),
        .push_word  (push_word),
        .pop        (bus.d_wr_ld),
        .pop_word   (pop_word),
        .pop_vld    (pop_vld),
        .lvl        (wf_lvl),
        .ovf        (wf_ovf),
        .udf        (wf_udf)
    );

    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            sdr_dq_o  <= '0;
            sdr_dm_o  <= '0;
            sdr_dq_oe <= 1'b0;
        end else if (!mcb_sclr_n) begin
            sdr_dq_o  <= '0;
            sdr_dm_o  <= '0;
            sdr_dq_oe <= 1'b0;
        end else begin
            sdr_dq_oe <= bus.d_dp_oe;
            if (bus.d_wr_ld) begin
                // Starved load keeps DQ but masks every byte.
                if (pop_vld) begin
                    sdr_dq_o <= pop_word.dq;
                    sdr_dm_o <= pop_word.dm;
                end else begin
                    sdr_dm_o <= '1;
                end
            end else if (!bus.d_dp_oe) begin
                sdr_dm_o <= '0;
            end
        end
    end

    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst)
            bus.mcb_rdat <= '0;
        else if (!mcb_sclr_n)
            bus.mcb_rdat <= '0;
        else if (bus.d_dp_ie)
            bus.mcb_rdat <= sdr_dq_i;
    end

endmodule

// File: tb/tb_mcb_dat_path.sv
// Self-checking bench for mcb_dat_path: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_mcb_dat_path;
    import mcb_dat_path_pkg::*;

    logic        mcb_clk;
    logic        mcb_rst;
    logic        mcb_sclr_n;
    logic [15:0] sdr_dq_i;
    logic [15:0] sdr_dq_o;
    logic        sdr_dq_oe;
    logic [1:0]  sdr_dm_o;
    wf_lvl_t     wf_lvl;
    logic        wf_ovf;
    logic        wf_udf;

    int n_vec;
    int n_err;

    mcb_dat_path_if bus ();

    mcb_dat_path dut (
        .mcb_clk    (mcb_clk),
        .mcb_rst    (mcb_rst),
        .mcb_sclr_n (mcb_sclr_n),
        .bus        (bus),
        .sdr_dq_i   (sdr_dq_i),
        .sdr_dq_o   (sdr_dq_o),
        .sdr_dq_oe  (sdr_dq_oe),
        .sdr_dm_o   (sdr_dm_o),
        .wf_lvl     (wf_lvl),
        .wf_ovf     (wf_ovf),
        .wf_udf     (wf_udf)
    );

    initial mcb_clk = 1'b0;
    always #5 mcb_clk = ~mcb_clk;

    wf_word_t    q[$];
    logic [15:0] m_dq;
    logic [1:0]  m_dm;
    logic        m_oe;
    logic [15:0] m_rdat;
    logic        m_ovf;
    logic        m_udf;

    function automatic logic [39:0] dut_vec();
        return {sdr_dq_o, sdr_dm_o, sdr_dq_oe, bus.mcb_rdat,
                wf_lvl, wf_ovf, wf_udf};
    endfunction

    function automatic logic [39:0] mdl_vec();
        logic [2:0] l;
        l = 3'(q.size());
        return {m_dq, m_dm, m_oe, m_rdat, l, m_ovf, m_udf};
    endfunction

    task automatic model_clear();
        q.delete();
        m_dq = '0; m_dm = '0; m_oe = 0;
        m_rdat = '0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic step(input logic sclr, input logic req,
                        input logic [15:0] wd, input logic [1:0] wm,
                        input logic ld, input logic oe,
                        input logic ie, input logic [15:0] dqi);
        wf_word_t w;
        wf_word_t h;
        mcb_sclr_n       = ~sclr;
        bus.mcb_wdat_req = req;
        bus.mcb_wdat     = wd;
        bus.mcb_wdm      = wm;
        bus.d_wr_ld      = ld;
        bus.d_dp_oe      = oe;
        bus.d_dp_ie      = ie;
        sdr_dq_i         = dqi;
        @(posedge mcb_clk);
        #1;
        w.dq = wd;
        w.dm = wm;
        if (sclr) begin
            model_clear();
        end else begin
            if (ld && q.size() == 0 && req) begin
                m_dq = wd;
                m_dm = wm;
            end else begin
                if (ld) begin
                    if (q.size() > 0) begin
                        h = q.pop_front();
                        m_dq = h.dq;
                        m_dm = h.dm;
                    end else begin
                        m_dm = 2'b11;
                        m_udf = 1;
                    end
                end
                if (req) begin
                    if (q.size() < WF_DEPTH) q.push_back(w);
                    else m_ovf = 1;
                end
            end
            if (!ld && !oe) m_dm = 2'b00;
            m_oe = oe;
            if (ie) m_rdat = dqi;
        end
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 2'b0, 0, 0, 0, 16'h0);
    endtask

    task automatic test_reset();
        mcb_rst = 1'b1;
        mcb_sclr_n = 1'b1;
        bus.mcb_wdat_req = 0; bus.mcb_wdat = '0; bus.mcb_wdm = '0;
        bus.d_wr_ld = 0; bus.d_dp_oe = 0; bus.d_dp_ie = 0;
        sdr_dq_i = '0;
        model_clear();
        repeat (2) @(posedge mcb_clk);
        #2 mcb_rst = 1'b0;
        idle();
        n_vec++;
        if (dut_vec() !== 40'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h",
                     dut_vec(), 40'h0);
        end
        step(0, 1, 16'h7701, 2'b01, 0, 0, 0, 16'h0);
        step(0, 1, 16'h7702, 2'b00, 1, 1, 1, 16'hBEEF);
        step(0, 1, 16'h7703, 2'b00, 1, 1, 0, 16'h0);
        n_vec++;
        if (dut_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL pre_reset: got %h want %h",
                     dut_vec(), mdl_vec());
        end
        #2 mcb_rst = 1'b1;
        #1;
        model_clear();
        n_vec++;
        if ({sdr_dq_oe, sdr_dq_o, wf_lvl, wf_ovf, wf_udf} !== 22'h0) begin
            n_err++;
            $display("FAIL async_reset: oe=%b dq=%h lvl=%0d ovf=%b udf=%b want 0",
                     sdr_dq_oe, sdr_dq_o, wf_lvl, wf_ovf, wf_udf);
        end
        @(negedge mcb_clk);
        mcb_rst = 1'b0;
        idle();
        n_vec++;
        if (dut_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL post_reset: got %h want %h",
                     dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_prefetch_burst();
        logic [15:0] want;
        step(0, 1, 16'hA001, 2'b00, 0, 0, 0, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            step(0, k < 4, 16'(16'hA001 + k), 2'b00, 1, 1, 0, 16'h0);
            want = 16'(16'hA000 + k);
            n_vec++;
            if (sdr_dq_o !== want || sdr_dq_oe !== 1'b1 ||
                dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL burst_%0d: dq=%h oe=%b got %h want dq=%h oe=1 %h",
                         k, sdr_dq_o, sdr_dq_oe, dut_vec(), want, mdl_vec());
            end
        end
        n_vec++;
        if (wf_lvl !== 3'd0) begin
            n_err++;
            $display("FAIL burst_lvl: got %0d want 0", wf_lvl);
        end
        idle();
    endtask

    task automatic test_fall_through();
        step(0, 1, 16'h1234, 2'b00, 1, 1, 0, 16'h0);
        n_vec++;
        if (sdr_dq_o !== 16'h1234 || wf_lvl !== 3'd0 ||
            dut_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL fall_through: dq=%h lvl=%0d want dq=1234 lvl=0",
                     sdr_dq_o, wf_lvl);
        end
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++)
            step(0, 1, 16'(16'hB000 + i), 2'(i), 0, 0, 0, 16'h0);
        n_vec++;
        if (wf_lvl !== 3'd4 || wf_ovf !== 1'b1 ||
            dut_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL ovf_flag: lvl=%0d ovf=%b want lvl=4 ovf=1",
                     wf_lvl, wf_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, 2'b0, 1, 1, 0, 16'h0);
            n_vec++;
            if (sdr_dq_o !== 16'(16'hB000 + i) ||
                dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL ovf_pop_%0d: dq=%h want %h",
                         i, sdr_dq_o, 16'(16'hB000 + i));
            end
        end
        step(1, 0, 16'h0, 2'b0, 0, 0, 0, 16'h0);
        n_vec++;
        if (wf_ovf !== 1'b0 || dut_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL ovf_sclr: ovf=%b want 0", wf_ovf);
        end
    endtask

    task automatic test_underflow();
        step(0, 1, 16'h5A5A, 2'b00, 1, 1, 0, 16'h0);
        step(0, 0, 16'h0, 2'b00, 1, 1, 0, 16'h0);
        n_vec++;
        if (sdr_dm_o !== 2'b11 || sdr_dq_o !== 16'h5A5A ||
            wf_udf !== 1'b1 || dut_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL udf: dm=%b dq=%h udf=%b want dm=11 dq=5a5a udf=1",
                     sdr_dm_o, sdr_dq_o, wf_udf);
        end
        repeat (3) idle();
        n_vec++;
        if (wf_udf !== 1'b1) begin
            n_err++;
            $display("FAIL udf_sticky: udf=%b want 1", wf_udf);
        end
        step(1, 0, 16'h0, 2'b0, 0, 0, 0, 16'h0);
        n_vec++;
        if (wf_udf !== 1'b0 || dut_vec() !== mdl_vec()) begin
            n_err++;
            $display("FAIL udf_sclr: udf=%b want 0", wf_udf);
        end
    endtask

    task automatic test_read();
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 16'h0, 2'b0, 0, 0, 1, 16'(i));
            n_vec++;
            if (bus.mcb_rdat !== 16'(i) || sdr_dm_o !== 2'b00 ||
                dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL read_%0d: rdat=%h dm=%b want rdat=%h dm=00",
                         i, bus.mcb_rdat, sdr_dm_o, 16'(i));
            end
        end
        step(0, 0, 16'h0, 2'b0, 0, 0, 0, 16'hFFFF);
        n_vec++;
        if (bus.mcb_rdat !== 16'h0004) begin
            n_err++;
            $display("FAIL read_hold: rdat=%h want 0004", bus.mcb_rdat);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 99) < 55),
                 16'($urandom), 2'($urandom),
                 ($urandom_range(0, 99) < 50),
                 1'($urandom), 1'($urandom), 16'($urandom));
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL random_%0d: got %h want %h",
                         i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_prefetch_burst();
        test_fall_through();
        test_overflow();
        test_underflow();
        test_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
